// File: rtl/reservation_station_pkg.sv
// Shared widths, the empty-tag constant and the per-entry state encoding
// for the reservation station.
package reservation_station_pkg;
  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;
  localparam logic [TAG_W-1:0] NO_TAG = 3'd0;

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_WAITING   = 2'd1,
    ST_READY     = 2'd2,
    ST_EXECUTING = 2'd3
  } entry_state_t;
endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, common-data-bus snoop and functional-unit issue signals of the
// reservation station; the station itself is the slave side.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic              dispatch_valid;
  logic              dispatch_ready;
  logic [TAG_W-1:0]  qj;
  logic [TAG_W-1:0]  qk;
  logic [DATA_W-1:0] vj;
  logic [DATA_W-1:0] vk;
  logic [TAG_W-1:0]  dispatch_tag;
  logic              bus_valid;
  logic [TAG_W-1:0]  bus_tag;
  logic [DATA_W-1:0] bus_value;
  logic              fu_ready;
  logic              new_instruction;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [TAG_W-1:0]  instruction_tag;

  modport master (
    output dispatch_valid, qj, qk, vj, vk, bus_valid, bus_tag, bus_value, fu_ready,
    input  dispatch_ready, dispatch_tag, new_instruction, a, b, instruction_tag
  );

  modport slave (
    input  dispatch_valid, qj, qk, vj, vk, bus_valid, bus_tag, bus_value, fu_ready,
    output dispatch_ready, dispatch_tag, new_instruction, a, b, instruction_tag
  );
endinterface

// File: rtl/reservation_station_rs_entry.sv
// One reservation-station entry: state, operand tags/values, dispatch-time
// bypass from the bus and bus snooping while waiting or executing.
module rs_entry
  import reservation_station_pkg::*;
#(
  parameter logic [TAG_W-1:0] TAG = 3'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch_en,
  input  logic [TAG_W-1:0]  qj,
  input  logic [TAG_W-1:0]  qk,
  input  logic [DATA_W-1:0] vj,
  input  logic [DATA_W-1:0] vk,
  input  logic              bus_valid,
  input  logic [TAG_W-1:0]  bus_tag,
  input  logic [DATA_W-1:0] bus_value,
  input  logic              issue_en,
  output entry_state_t      state,
  output entry_state_t      state_next,
  output logic [DATA_W-1:0] val_j,
  output logic [DATA_W-1:0] val_k
);
  entry_state_t      state_r;
  logic [TAG_W-1:0]  qj_r, qk_r, qj_n, qk_n;
  logic [DATA_W-1:0] vj_r, vk_r, vj_n, vk_n;
  logic              hit_j_s, hit_k_s;

  // Next entry contents: bypass on dispatch, capture while waiting, free on own broadcast
  always_comb begin
    state_next = state_r;
    qj_n       = qj_r;
    qk_n       = qk_r;
    vj_n       = vj_r;
    vk_n       = vk_r;
    hit_j_s    = 1'b0;
    hit_k_s    = 1'b0;
    case (state_r)
      ST_FREE: begin
        if (dispatch_en) begin
          hit_j_s    = bus_valid && (qj != NO_TAG) && (bus_tag == qj);
          hit_k_s    = bus_valid && (qk != NO_TAG) && (bus_tag == qk);
          qj_n       = hit_j_s ? NO_TAG : qj;
          qk_n       = hit_k_s ? NO_TAG : qk;
          vj_n       = hit_j_s ? bus_value : ((qj == NO_TAG) ? vj : {DATA_W{1'b0}});
          vk_n       = hit_k_s ? bus_value : ((qk == NO_TAG) ? vk : {DATA_W{1'b0}});
          state_next = ((qj_n == NO_TAG) && (qk_n == NO_TAG)) ? ST_READY : ST_WAITING;
        end else begin
          state_next = ST_FREE;
        end
      end
      ST_WAITING: begin
        hit_j_s    = bus_valid && (bus_tag != NO_TAG) && (qj_r == bus_tag);
        hit_k_s    = bus_valid && (bus_tag != NO_TAG) && (qk_r == bus_tag);
        qj_n       = hit_j_s ? NO_TAG : qj_r;
        qk_n       = hit_k_s ? NO_TAG : qk_r;
        vj_n       = hit_j_s ? bus_value : vj_r;
        vk_n       = hit_k_s ? bus_value : vk_r;
        state_next = ((qj_n == NO_TAG) && (qk_n == NO_TAG)) ? ST_READY : ST_WAITING;
      end
      ST_READY: begin
        state_next = issue_en ? ST_EXECUTING : ST_READY;
      end
      ST_EXECUTING: begin
        if (bus_valid && (bus_tag == TAG)) begin
          state_next = ST_FREE;
          qj_n       = NO_TAG;
          qk_n       = NO_TAG;
          vj_n       = {DATA_W{1'b0}};
          vk_n       = {DATA_W{1'b0}};
        end else begin
          state_next = ST_EXECUTING;
        end
      end
      default: begin
        state_next = ST_FREE;
      end
    endcase
  end

  // Entry state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FREE;
      qj_r    <= NO_TAG;
      qk_r    <= NO_TAG;
      vj_r    <= {DATA_W{1'b0}};
      vk_r    <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_next;
      qj_r    <= qj_n;
      qk_r    <= qk_n;
      vj_r    <= vj_n;
      vk_r    <= vk_n;
    end
  end

  assign state = state_r;
  assign val_j = vj_r;
  assign val_k = vk_r;
endmodule

// File: rtl/reservation_station.sv
// Reservation station top: lowest-index FREE selection for dispatch,
// lowest-index READY selection for issue, and the registered FU outputs.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int TAG_BASE = 1
) (
  input logic                  clk,
  input logic                  rst,
  reservation_station_if.slave rs
);
  localparam int IDX_W = 3;

  entry_state_t      state_s      [DEPTH];
  entry_state_t      state_next_s [DEPTH];
  logic [DATA_W-1:0] val_j_s      [DEPTH];
  logic [DATA_W-1:0] val_k_s      [DEPTH];
  logic [DEPTH-1:0]  dispatch_en_s;
  logic [DEPTH-1:0]  issue_en_s;

  logic              any_exec_s, any_ready_s, any_free_next_s, issue_s;
  logic [IDX_W-1:0]  ready_idx_s, free_idx_next_s;
  logic [DATA_W-1:0] sel_j_s, sel_k_s;

  logic              dispatch_ready_r;
  logic [IDX_W-1:0]  dispatch_idx_r;
  logic [TAG_W-1:0]  dispatch_tag_r;
  logic              new_instruction_r;
  logic [DATA_W-1:0] a_r, b_r;
  logic [TAG_W-1:0]  instruction_tag_r;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign dispatch_en_s[g] = rs.dispatch_valid && dispatch_ready_r && (dispatch_idx_r == IDX_W'(g));
    assign issue_en_s[g]    = issue_s && (ready_idx_s == IDX_W'(g));

    rs_entry #(.TAG(TAG_W'(TAG_BASE + g))) u_entry (
      .clk        (clk),
      .rst        (rst),
      .dispatch_en(dispatch_en_s[g]),
      .qj         (rs.qj),
      .qk         (rs.qk),
      .vj         (rs.vj),
      .vk         (rs.vk),
      .bus_valid  (rs.bus_valid),
      .bus_tag    (rs.bus_tag),
      .bus_value  (rs.bus_value),
      .issue_en   (issue_en_s[g]),
      .state      (state_s[g]),
      .state_next (state_next_s[g]),
      .val_j      (val_j_s[g]),
      .val_k      (val_k_s[g])
    );
  end

  // Priority scan (descending so the lowest index wins) for issue and next dispatch slot
  always_comb begin
    any_exec_s      = 1'b0;
    any_ready_s     = 1'b0;
    any_free_next_s = 1'b0;
    ready_idx_s     = 3'd0;
    free_idx_next_s = 3'd0;
    sel_j_s         = {DATA_W{1'b0}};
    sel_k_s         = {DATA_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      any_exec_s = any_exec_s | (state_s[i] == ST_EXECUTING);
      if (state_s[i] == ST_READY) begin
        any_ready_s = 1'b1;
        ready_idx_s = IDX_W'(i);
        sel_j_s     = val_j_s[i];
        sel_k_s     = val_k_s[i];
      end else begin
        any_ready_s = any_ready_s;
      end
      if (state_next_s[i] == ST_FREE) begin
        any_free_next_s = 1'b1;
        free_idx_next_s = IDX_W'(i);
      end else begin
        any_free_next_s = any_free_next_s;
      end
    end
    issue_s = rs.fu_ready && !any_exec_s && any_ready_s;
  end

  // Registered dispatch status and FU issue outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dispatch_ready_r  <= 1'b1;
      dispatch_idx_r    <= 3'd0;
      dispatch_tag_r    <= TAG_W'(TAG_BASE);
      new_instruction_r <= 1'b0;
      a_r               <= {DATA_W{1'b0}};
      b_r               <= {DATA_W{1'b0}};
      instruction_tag_r <= NO_TAG;
    end else begin
      dispatch_ready_r  <= any_free_next_s;
      dispatch_idx_r    <= free_idx_next_s;
      dispatch_tag_r    <= TAG_W'(TAG_BASE) + free_idx_next_s;
      new_instruction_r <= issue_s;
      if (issue_s) begin
        a_r               <= sel_j_s;
        b_r               <= sel_k_s;
        instruction_tag_r <= TAG_W'(TAG_BASE) + ready_idx_s;
      end else begin
        a_r               <= a_r;
        b_r               <= b_r;
        instruction_tag_r <= instruction_tag_r;
      end
    end
  end

  assign rs.dispatch_ready  = dispatch_ready_r;
  assign rs.dispatch_tag    = dispatch_tag_r;
  assign rs.new_instruction = new_instruction_r;
  assign rs.a               = a_r;
  assign rs.b               = b_r;
  assign rs.instruction_tag = instruction_tag_r;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station (DEPTH=3, TAG_BASE=1): dispatch,
// wakeup, bypass, full handling, in-order issue and reset while executing.
module tb_reservation_station;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  reservation_station_if rs_bus ();

  reservation_station #(.DEPTH(3), .TAG_BASE(1)) dut (
    .clk(clk),
    .rst(rst),
    .rs (rs_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    rs_bus.bus_valid = 1'b0;
    rs_bus.bus_tag   = 3'd0;
    rs_bus.bus_value = 32'd0;
  endtask

  task automatic broadcast(input logic [2:0] tag, input logic [31:0] value);
    rs_bus.bus_valid = 1'b1;
    rs_bus.bus_tag   = tag;
    rs_bus.bus_value = value;
    step();
    bus_idle();
  endtask

  task automatic drive_dispatch(input logic [2:0] qj, input logic [2:0] qk,
                                input logic [31:0] vj, input logic [31:0] vk);
    rs_bus.dispatch_valid = 1'b1;
    rs_bus.qj = qj;
    rs_bus.qk = qk;
    rs_bus.vj = vj;
    rs_bus.vk = vk;
  endtask

  task automatic dispatch_off();
    rs_bus.dispatch_valid = 1'b0;
    rs_bus.qj = 3'd0;
    rs_bus.qk = 3'd0;
    rs_bus.vj = 32'd0;
    rs_bus.vk = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dispatch_off();
    bus_idle();
    rs_bus.fu_ready = 1'b0;
    #12;
    total++; if (rs_bus.dispatch_ready !== 1'b1) begin bad++; $display("FAIL reset_dispatch_ready: got %0b want 1", rs_bus.dispatch_ready); end
    total++; if (rs_bus.dispatch_tag !== 3'd1) begin bad++; $display("FAIL reset_dispatch_tag: got %0d want 1", rs_bus.dispatch_tag); end
    total++; if (rs_bus.new_instruction !== 1'b0) begin bad++; $display("FAIL reset_new_instruction: got %0b want 0", rs_bus.new_instruction); end
    total++; if (rs_bus.a !== 32'd0 || rs_bus.b !== 32'd0) begin bad++; $display("FAIL reset_ab: got a=%0d b=%0d want 0 0", rs_bus.a, rs_bus.b); end
    total++; if (rs_bus.instruction_tag !== 3'd0) begin bad++; $display("FAIL reset_instruction_tag: got %0d want 0", rs_bus.instruction_tag); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_issue();
    rs_bus.fu_ready = 1'b1;
    drive_dispatch(3'd0, 3'd0, 32'd5, 32'd7);
    step();
    dispatch_off();
    total++; if (rs_bus.dispatch_tag !== 3'd2) begin bad++; $display("FAIL issue_next_dispatch_tag: got %0d want 2", rs_bus.dispatch_tag); end
    step();
    total++; if (rs_bus.new_instruction !== 1'b1) begin bad++; $display("FAIL issue_pulse: got %0b want 1", rs_bus.new_instruction); end
    total++; if (rs_bus.a !== 32'd5 || rs_bus.b !== 32'd7) begin bad++; $display("FAIL issue_ab: got a=%0d b=%0d want 5 7", rs_bus.a, rs_bus.b); end
    total++; if (rs_bus.instruction_tag !== 3'd1) begin bad++; $display("FAIL issue_tag: got %0d want 1", rs_bus.instruction_tag); end
    step();
    total++; if (rs_bus.new_instruction !== 1'b0 || rs_bus.a !== 32'd5) begin bad++; $display("FAIL issue_one_pulse_hold: got ni=%0b a=%0d want 0 5", rs_bus.new_instruction, rs_bus.a); end
    broadcast(3'd1, 32'd99);
    total++; if (rs_bus.dispatch_tag !== 3'd1 || rs_bus.dispatch_ready !== 1'b1) begin bad++; $display("FAIL issue_freed: got tag=%0d rdy=%0b want 1 1", rs_bus.dispatch_tag, rs_bus.dispatch_ready); end
  endtask

  task automatic test_wakeup();
    rs_bus.fu_ready = 1'b1;
    drive_dispatch(3'd4, 3'd0, 32'd0, 32'd3);
    step();
    dispatch_off();
    broadcast(3'd0, 32'd55);
    total++; if (rs_bus.new_instruction !== 1'b0) begin bad++; $display("FAIL wakeup_waiting: got %0b want 0", rs_bus.new_instruction); end
    broadcast(3'd4, 32'd10);
    total++; if (rs_bus.new_instruction !== 1'b0) begin bad++; $display("FAIL wakeup_no_same_cycle_issue: got %0b want 0", rs_bus.new_instruction); end
    step();
    total++; if (rs_bus.new_instruction !== 1'b1 || rs_bus.instruction_tag !== 3'd1) begin bad++; $display("FAIL wakeup_issue: got ni=%0b tag=%0d want 1 1", rs_bus.new_instruction, rs_bus.instruction_tag); end
    total++; if (rs_bus.a !== 32'd10 || rs_bus.b !== 32'd3) begin bad++; $display("FAIL wakeup_ab: got a=%0d b=%0d want 10 3", rs_bus.a, rs_bus.b); end
    broadcast(3'd1, 32'd0);
    total++; if (rs_bus.dispatch_tag !== 3'd1) begin bad++; $display("FAIL wakeup_freed: got %0d want 1", rs_bus.dispatch_tag); end
  endtask

  task automatic test_full_and_order();
    rs_bus.fu_ready = 1'b0;
    drive_dispatch(3'd0, 3'd0, 32'd10, 32'd20); step();
    drive_dispatch(3'd0, 3'd0, 32'd11, 32'd21); step();
    drive_dispatch(3'd0, 3'd0, 32'd12, 32'd22); step();
    total++; if (rs_bus.dispatch_ready !== 1'b0) begin bad++; $display("FAIL full_not_ready: got %0b want 0", rs_bus.dispatch_ready); end
    drive_dispatch(3'd0, 3'd0, 32'd77, 32'd77); step();
    total++; if (rs_bus.dispatch_ready !== 1'b0) begin bad++; $display("FAIL full_ignore: got %0b want 0", rs_bus.dispatch_ready); end
    dispatch_off();
    rs_bus.fu_ready = 1'b1;
    step();
    total++; if (rs_bus.new_instruction !== 1'b1 || rs_bus.instruction_tag !== 3'd1 || rs_bus.a !== 32'd10 || rs_bus.b !== 32'd20) begin bad++; $display("FAIL order_first: got ni=%0b tag=%0d a=%0d b=%0d want 1 1 10 20", rs_bus.new_instruction, rs_bus.instruction_tag, rs_bus.a, rs_bus.b); end
    step();
    total++; if (rs_bus.new_instruction !== 1'b0 || rs_bus.instruction_tag !== 3'd1) begin bad++; $display("FAIL order_single_exec: got ni=%0b tag=%0d want 0 1", rs_bus.new_instruction, rs_bus.instruction_tag); end
    broadcast(3'd1, 32'd0);
    total++; if (rs_bus.dispatch_ready !== 1'b1 || rs_bus.dispatch_tag !== 3'd1 || rs_bus.new_instruction !== 1'b0) begin bad++; $display("FAIL full_freed: got rdy=%0b tag=%0d ni=%0b want 1 1 0", rs_bus.dispatch_ready, rs_bus.dispatch_tag, rs_bus.new_instruction); end
    step();
    total++; if (rs_bus.new_instruction !== 1'b1 || rs_bus.instruction_tag !== 3'd2 || rs_bus.a !== 32'd11) begin bad++; $display("FAIL order_second: got ni=%0b tag=%0d a=%0d want 1 2 11", rs_bus.new_instruction, rs_bus.instruction_tag, rs_bus.a); end
    broadcast(3'd2, 32'd0);
    step();
    total++; if (rs_bus.new_instruction !== 1'b1 || rs_bus.instruction_tag !== 3'd3 || rs_bus.b !== 32'd22) begin bad++; $display("FAIL order_third: got ni=%0b tag=%0d b=%0d want 1 3 22", rs_bus.new_instruction, rs_bus.instruction_tag, rs_bus.b); end
    broadcast(3'd3, 32'd0);
    step();
    total++; if (rs_bus.new_instruction !== 1'b0 || rs_bus.dispatch_tag !== 3'd1) begin bad++; $display("FAIL full_drained: got ni=%0b tag=%0d want 0 1", rs_bus.new_instruction, rs_bus.dispatch_tag); end
  endtask

  task automatic test_bypass();
    rs_bus.fu_ready = 1'b0;
    drive_dispatch(3'd5, 3'd0, 32'd0, 32'd4);
    rs_bus.bus_valid = 1'b1;
    rs_bus.bus_tag   = 3'd5;
    rs_bus.bus_value = 32'd9;
    step();
    bus_idle();
    dispatch_off();
    rs_bus.fu_ready = 1'b1;
    step();
    total++; if (rs_bus.new_instruction !== 1'b1 || rs_bus.a !== 32'd9 || rs_bus.b !== 32'd4) begin bad++; $display("FAIL bypass: got ni=%0b a=%0d b=%0d want 1 9 4", rs_bus.new_instruction, rs_bus.a, rs_bus.b); end
    broadcast(3'd1, 32'd0);
  endtask

  task automatic test_reset_exec();
    rs_bus.fu_ready = 1'b1;
    drive_dispatch(3'd0, 3'd0, 32'd33, 32'd44);
    step();
    dispatch_off();
    step();
    total++; if (rs_bus.new_instruction !== 1'b1 || rs_bus.a !== 32'd33) begin bad++; $display("FAIL rstexec_issue: got ni=%0b a=%0d want 1 33", rs_bus.new_instruction, rs_bus.a); end
    #3 rst = 1'b1;
    #1;
    total++; if (rs_bus.new_instruction !== 1'b0 || rs_bus.a !== 32'd0 || rs_bus.b !== 32'd0 || rs_bus.instruction_tag !== 3'd0) begin bad++; $display("FAIL rstexec_outputs: got ni=%0b a=%0d b=%0d tag=%0d want 0 0 0 0", rs_bus.new_instruction, rs_bus.a, rs_bus.b, rs_bus.instruction_tag); end
    total++; if (rs_bus.dispatch_ready !== 1'b1 || rs_bus.dispatch_tag !== 3'd1) begin bad++; $display("FAIL rstexec_dispatch: got rdy=%0b tag=%0d want 1 1", rs_bus.dispatch_ready, rs_bus.dispatch_tag); end
    #2 rst = 1'b0;
    step();
    broadcast(3'd1, 32'd123);
    total++; if (rs_bus.new_instruction !== 1'b0 || rs_bus.a !== 32'd0 || rs_bus.dispatch_tag !== 3'd1) begin bad++; $display("FAIL rstexec_stale_bcast: got ni=%0b a=%0d tag=%0d want 0 0 1", rs_bus.new_instruction, rs_bus.a, rs_bus.dispatch_tag); end
    drive_dispatch(3'd0, 3'd0, 32'd1, 32'd2);
    step();
    dispatch_off();
    total++; if (rs_bus.dispatch_tag !== 3'd2) begin bad++; $display("FAIL rstexec_reuse: got %0d want 2", rs_bus.dispatch_tag); end
    step();
    total++; if (rs_bus.new_instruction !== 1'b1 || rs_bus.a !== 32'd1 || rs_bus.instruction_tag !== 3'd1) begin bad++; $display("FAIL rstexec_reissue: got ni=%0b a=%0d tag=%0d want 1 1 1", rs_bus.new_instruction, rs_bus.a, rs_bus.instruction_tag); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_issue();
    test_wakeup();
    test_full_and_order();
    test_bypass();
    test_reset_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
